// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU select codes, ALUOp encodings and issue FSM state type
package alu_pkg;

    localparam logic [3:0] SEL_AND   = 4'b0000;
    localparam logic [3:0] SEL_OR    = 4'b0001;
    localparam logic [3:0] SEL_ADD   = 4'b0010;
    localparam logic [3:0] SEL_SUB   = 4'b0110;
    localparam logic [3:0] SEL_PASSB = 4'b0111;
    localparam logic [3:0] SEL_NOR   = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASSB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } issue_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational ALUOp/funct decode to ALU select
// Optional NOR decode enabled by macro ALU_ISSUE_NOR_EN.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] sel,
    output logic       illegal
);

    always_comb begin
        sel     = SEL_PASSB;
        illegal = 1'b0;
        case (ALUOp)
            ALUOP_ADD:   sel = SEL_ADD;
            ALUOP_SUB:   sel = SEL_SUB;
            ALUOP_PASSB: sel = SEL_PASSB;
            default: begin
                // Illegal funct combinations fall through as PASSB with the flag set
                illegal = 1'b1;
                if (funct3 == 3'b000) begin
                    sel     = funct7_5 ? SEL_SUB : SEL_ADD;
                    illegal = 1'b0;
                end else if (funct3 == 3'b111) begin
                    sel     = SEL_AND;
                    illegal = 1'b0;
                end else if (funct3 == 3'b110) begin
                    sel     = SEL_OR;
                    illegal = 1'b0;
                end
`ifdef ALU_ISSUE_NOR_EN
                else if (funct3 == 3'b100 && funct7_5) begin
                    sel     = SEL_NOR;
                    illegal = 1'b0;
                end
`endif
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue controller: accept, drive external ALU for one cycle, hold result
// Optional NOR decode enabled by macro ALU_ISSUE_NOR_EN (see alu_op_decode).
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int n = 63
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   ALUOp,
    input  logic [2:0]   funct3,
    input  logic         funct7_5,
    input  logic [n:0]   op_a,
    input  logic [n:0]   op_b,
    output logic [3:0]   alu_sel,
    output logic [n:0]   alu_a,
    output logic [n:0]   alu_b,
    input  logic [n:0]   alu_result,
    input  logic         alu_zero,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n:0]   out_result,
    output logic         out_zero,
    output logic         out_err
);

    issue_state_t state_q, state_d;
    logic [3:0]   dec_sel;
    logic         dec_illegal;
    logic         illegal_q;

    alu_op_decode u_decode (
        .ALUOp    (ALUOp),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .sel      (dec_sel),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = ~reset;
                if (in_valid) state_d = ST_EXEC;
            end
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU drive registers only change on accept, so the ALU ports never glitch between ops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_sel    <= 4'b0000;
            alu_a      <= '0;
            alu_b      <= '0;
            illegal_q  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && in_valid) begin
                alu_sel   <= dec_sel;
                alu_a     <= op_a;
                alu_b     <= op_b;
                illegal_q <= dec_illegal;
            end
            if (state_q == ST_EXEC) begin
                if (illegal_q) begin
                    out_result <= '0;
                    out_zero   <= 1'b1;
                    out_err    <= 1'b1;
                end else begin
                    out_result <= alu_result;
                    out_zero   <= alu_zero;
                    out_err    <= 1'b0;
                end
            end
        end
    end

endmodule
